// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush sequencer bus: requests from ID/EX/MEM into the controller,
// per-stage stall bus, flush redirect and multi-cycle status back out.
interface pipe_stall_ctrl_if #(
  parameter int STALL_W = 6,
  parameter int LEN_W   = 6,
  parameter int PERF_W  = 32
);
  logic               stallreq_id;
  logic               ex_mc_start;
  logic [LEN_W-1:0]   ex_mc_len;
  logic               excp_valid;
  logic [31:0]        excp_pc;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [31:0]        flush_pc;
  logic               mc_done;
  logic               mc_busy;
  logic [PERF_W-1:0]  perf_stall;

  // Pipeline side: raises requests, consumes stall/flush/status
  modport master (
    output stallreq_id, ex_mc_start, ex_mc_len, excp_valid, excp_pc,
    input  stall, flush, flush_pc, mc_done, mc_busy, perf_stall
  );

  // Controller side
  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_len, excp_valid, excp_pc,
    output stall, flush, flush_pc, mc_done, mc_busy, perf_stall
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core.
// Priority each cycle: exception flush > multi-cycle busy > multi-cycle start > load-use.
// stall/flush/mc_done are combinational (zero latency); only state, the
// occupancy counter and the stall-cycle counter are registered.
module pipe_stall_ctrl #(
  parameter int STALL_W = 6,
  parameter int LEN_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active-low
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // PC/IF/ID held, EX bubbled (load-use)
  localparam logic [STALL_W-1:0] STALL_HAZ = STALL_W'(6'b000111);
  // PC/IF/ID/EX all held (multi-cycle op occupying EX)
  localparam logic [STALL_W-1:0] STALL_MC  = STALL_W'(6'b001111);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  perf_q;

  logic [STALL_W-1:0] stall_c;
  logic               flush_c;
  logic [31:0]        flush_pc_c;
  logic               mc_done_c;

  // Next-state and combinational stall/flush decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = '0;
    flush_c    = 1'b0;
    flush_pc_c = '0;
    mc_done_c  = 1'b0;

    if (bus.excp_valid) begin
      // Flush abandons any multi-cycle op without signalling completion
      flush_c    = 1'b1;
      flush_pc_c = bus.excp_pc;
      state_d    = IDLE;
      cnt_d      = '0;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        stall_c = STALL_MC;
        cnt_d   = cnt_q - LEN_W'(1);
      end else begin
        // Final cycle: EX released, result valid; load-use may still hold front end
        mc_done_c = 1'b1;
        state_d   = IDLE;
        if (bus.stallreq_id) begin
          stall_c = STALL_HAZ;
        end
      end
    end else if (bus.ex_mc_start) begin
      if (bus.ex_mc_len >= LEN_W'(2)) begin
        // Start cycle counts toward length, final cycle is the cnt==0 cycle
        stall_c = STALL_MC;
        cnt_d   = bus.ex_mc_len - LEN_W'(2);
        state_d = BUSY;
      end else begin
        mc_done_c = 1'b1;
      end
    end else if (bus.stallreq_id) begin
      stall_c = STALL_HAZ;
    end
  end

  // State and occupancy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall-cycle performance counter, counts cycles with the PC held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (stall_c[0]) begin
      perf_q <= perf_q + PERF_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held, whatever the inputs do
  assign bus.stall      = rst ? stall_c    : '0;
  assign bus.flush      = rst ? flush_c    : 1'b0;
  assign bus.flush_pc   = rst ? flush_pc_c : '0;
  assign bus.mc_done    = rst ? mc_done_c  : 1'b0;
  assign bus.mc_busy    = (state_q == BUSY);
  assign bus.perf_stall = perf_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: inputs change 1 time unit after the
// rising edge, combinational outputs are checked mid-cycle.
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  pipe_stall_ctrl_if #(.STALL_W(6), .LEN_W(6), .PERF_W(32)) bus ();

  pipe_stall_ctrl #(.STALL_W(6), .LEN_W(6), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_in();
    bus.stallreq_id = 1'b0;
    bus.ex_mc_start = 1'b0;
    bus.ex_mc_len   = '0;
    bus.excp_valid  = 1'b0;
    bus.excp_pc     = '0;
  endtask

  // Advance to 1 unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    idle_in();
    step();
    step();

    // Reset values
    #2;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_busy",  32'(bus.mc_busy), 32'h0);
    chk("rst_perf",  bus.perf_stall, 32'h0);
    rst = 1'b1;
    step();

    // Enter BUSY with cnt=5 (len 7), then reset asynchronously mid-cycle
    bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd7;
    step();
    idle_in();
    #2;
    chk("pre_rst_busy", 32'(bus.mc_busy), 32'h1);
    bus.stallreq_id = 1'b1;
    rst = 1'b0;
    #1;
    chk("async_rst_stall", 32'(bus.stall), 32'h0);
    chk("async_rst_busy",  32'(bus.mc_busy), 32'h0);
    chk("async_rst_perf",  bus.perf_stall, 32'h0);
    step();
    idle_in();
    rst = 1'b1;
    #2;
    chk("post_rst_busy", 32'(bus.mc_busy), 32'h0);
    chk("post_rst_stall", 32'(bus.stall), 32'h0);
    step();

    // Load-use for one cycle
    bus.stallreq_id = 1'b1;
    #2;
    chk("lu_stall", 32'(bus.stall), 32'h07);
    step();
    idle_in();
    #2;
    chk("lu_stall_after", 32'(bus.stall), 32'h0);
    chk("lu_perf", bus.perf_stall, 32'd1);
    step();

    // Multi-cycle len=4
    bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd4;
    #2;
    chk("mc4_c1_stall", 32'(bus.stall), 32'h0F);
    chk("mc4_c1_done",  32'(bus.mc_done), 32'h0);
    step();
    idle_in();
    #2;
    chk("mc4_c2_stall", 32'(bus.stall), 32'h0F);
    chk("mc4_c2_busy",  32'(bus.mc_busy), 32'h1);
    step();
    #2;
    chk("mc4_c3_stall", 32'(bus.stall), 32'h0F);
    chk("mc4_c3_done",  32'(bus.mc_done), 32'h0);
    step();
    #2;
    chk("mc4_c4_stall", 32'(bus.stall), 32'h0);
    chk("mc4_c4_done",  32'(bus.mc_done), 32'h1);
    step();
    #2;
    chk("mc4_after_busy", 32'(bus.mc_busy), 32'h0);
    chk("mc4_after_done", 32'(bus.mc_done), 32'h0);
    chk("mc4_perf", bus.perf_stall, 32'd4);

    // Short ops: len=1, then len=0 with a competing load-use request
    bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd1;
    #2;
    chk("len1_done",  32'(bus.mc_done), 32'h1);
    chk("len1_stall", 32'(bus.stall), 32'h0);
    step();
    chk("len1_busy", 32'(bus.mc_busy), 32'h0);
    bus.ex_mc_len = 6'd0; bus.stallreq_id = 1'b1;
    #2;
    chk("len0_done",  32'(bus.mc_done), 32'h1);
    chk("len0_stall", 32'(bus.stall), 32'h0);
    step();
    idle_in();
    #2;
    chk("len0_busy", 32'(bus.mc_busy), 32'h0);
    chk("len0_perf", bus.perf_stall, 32'd4);
    chk("idle_flush_pc", bus.flush_pc, 32'h0);
    step();

    // Exception in BUSY with cnt=2 (len 4 start, one cycle later)
    bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd4;
    step();
    idle_in();
    bus.excp_valid = 1'b1; bus.excp_pc = 32'hBFC00380;
    #2;
    chk("ex_flush",    32'(bus.flush), 32'h1);
    chk("ex_flush_pc", bus.flush_pc, 32'hBFC00380);
    chk("ex_stall",    32'(bus.stall), 32'h0);
    chk("ex_done",     32'(bus.mc_done), 32'h0);
    step();
    idle_in();
    #2;
    chk("ex_next_busy",  32'(bus.mc_busy), 32'h0);
    chk("ex_next_flush", 32'(bus.flush), 32'h0);
    chk("ex_next_pc",    bus.flush_pc, 32'h0);
    chk("ex_next_done",  32'(bus.mc_done), 32'h0);
    step();
    #2;
    chk("ex_late_done", 32'(bus.mc_done), 32'h0);
    chk("ex_perf", bus.perf_stall, 32'd5);

    // Load-use absorbed by len=3 start; load-use honoured in the final cycle
    bus.stallreq_id = 1'b1; bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd3;
    #2;
    chk("mc3_c1_stall", 32'(bus.stall), 32'h0F);
    step();
    idle_in();
    #2;
    chk("mc3_c2_stall", 32'(bus.stall), 32'h0F);
    chk("mc3_c2_done",  32'(bus.mc_done), 32'h0);
    step();
    bus.stallreq_id = 1'b1; bus.ex_mc_start = 1'b1; bus.ex_mc_len = 6'd5;
    #2;
    chk("mc3_c3_stall", 32'(bus.stall), 32'h07);
    chk("mc3_c3_done",  32'(bus.mc_done), 32'h1);
    step();
    idle_in();
    #2;
    chk("mc3_after_busy",  32'(bus.mc_busy), 32'h0);
    chk("mc3_after_stall", 32'(bus.stall), 32'h0);
    chk("mc3_perf", bus.perf_stall, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
